// File: rtl/dmem_ws_pkg.sv
// Shared types and helpers for the wait-state data memory (dmem_ws).
package dmem_ws_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD      = 2'd0,
        WR      = 2'd1,
        ILLEGAL = 2'd2
    } op_t;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

    // Width of the word index; clamped to 1 so a single-word memory still has a legal index.
    function automatic int word_index_width(input int size_in_bytes, input int data_width);
        int w;
        w = $clog2(size_in_bytes) - $clog2(data_width / 8);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_ws_array.sv
// Backing storage for dmem_ws: byte-lane-masked synchronous write, synchronous read.
// The read register can be cleared so rejected accesses return zero.
module dmem_ws_array
    import dmem_ws_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    re,
    input  logic                    clr,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH/8-1:0] mask,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit only the byte lanes whose mask bit is set; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (mask[l]) begin
                    mem[idx][l*8 +: 8] <= wdata[l*8 +: 8];
                end
            end
        end
    end

    // Read data register: loads on a read, zeroes on a rejected access, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ws.sv
// dmem_ws: data memory with programmable wait states and a ready/valid handshake.
// Optional build macro DMEM_WS_STATS_EN adds successful read/write counters.
module dmem_ws
    import dmem_ws_pkg::*;
#(
    parameter int SIZE_IN_BYTES = 4096,
    parameter int DATA_WIDTH    = 32,
    parameter int WAIT_STATES   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             ip_data_addr,
    input  logic                    ip_data_wr,
    input  logic [DATA_WIDTH/8-1:0] ip_data_mask,
    input  logic [DATA_WIDTH-1:0]   ip_data_from_proc,
    input  logic                    ip_data_rd,
    output logic                    op_data_ready,
    output logic                    op_data_valid,
    output logic                    op_data_err,
    output logic [DATA_WIDTH-1:0]   op_data_from_dmem
`ifdef DMEM_WS_STATS_EN
    ,
    output logic [31:0]             op_rd_count,
    output logic [31:0]             op_wr_count
`endif
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = word_index_width(SIZE_IN_BYTES, DATA_WIDTH);
    localparam int DEPTH = SIZE_IN_BYTES / LANES;
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    op_t                     req_op;
    logic                    req_oor;
    logic [IDX_W-1:0]        req_idx;
    logic [LANES-1:0]        req_mask;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    accept;
    op_t                     in_op;
    logic                    in_oor;
    logic [IDX_W-1:0]        in_idx;
    logic                    go_resp;
    op_t                     cur_op;
    logic                    cur_err;
    logic [IDX_W-1:0]        cur_idx;
    logic [LANES-1:0]        cur_mask;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic                    arr_we;
    logic                    arr_re;
    logic                    arr_clr;

    // Decode the incoming request and pick the operation that completes at the next edge:
    // with no wait states it is the request being accepted, otherwise the latched one.
    always_comb begin
        accept  = (ip_data_rd | ip_data_wr) & op_data_ready;
        in_oor  = ip_data_addr >= 32'(SIZE_IN_BYTES);
        in_idx  = IDX_W'(ip_data_addr >> OFF_W);
        in_op   = RD;
        if (ip_data_rd && ip_data_wr) begin
            in_op = ILLEGAL;
        end else if (ip_data_wr) begin
            in_op = WR;
        end

        go_resp = 1'b0;
        if (accept) begin
            go_resp = (WAIT_STATES == 0);
        end else if (state == WAIT && wait_cnt == '0) begin
            go_resp = 1'b1;
        end

        cur_op    = accept ? in_op             : req_op;
        cur_idx   = accept ? in_idx            : req_idx;
        cur_mask  = accept ? ip_data_mask      : req_mask;
        cur_wdata = accept ? ip_data_from_proc : req_wdata;
        cur_err   = (cur_op == ILLEGAL) | (accept ? in_oor : req_oor);

        arr_we  = go_resp & ~cur_err & (cur_op == WR);
        arr_re  = go_resp & ~cur_err & (cur_op == RD);
        arr_clr = go_resp & cur_err;
    end

    // Request FSM with registered ready/valid/err and the wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            op_data_ready <= 1'b1;
            op_data_valid <= 1'b0;
            op_data_err   <= 1'b0;
            req_op        <= RD;
            req_oor       <= 1'b0;
            req_idx       <= '0;
            req_mask      <= '0;
            req_wdata     <= '0;
        end else begin
            op_data_valid <= go_resp;
            op_data_err   <= go_resp & cur_err;
            if (accept) begin
                req_op    <= in_op;
                req_oor   <= in_oor;
                req_idx   <= in_idx;
                req_mask  <= ip_data_mask;
                req_wdata <= ip_data_from_proc;
                if (WAIT_STATES == 0) begin
                    state         <= RESP;
                    op_data_ready <= 1'b1;
                end else begin
                    state         <= WAIT;
                    op_data_ready <= 1'b0;
                    wait_cnt      <= CNT_LOAD;
                end
            end else begin
                case (state)
                    WAIT: begin
                        if (wait_cnt == '0) begin
                            state         <= RESP;
                            op_data_ready <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        op_data_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    dmem_ws_array #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .re    (arr_re),
        .clr   (arr_clr),
        .idx   (cur_idx),
        .mask  (cur_mask),
        .wdata (cur_wdata),
        .rdata (op_data_from_dmem)
    );

`ifdef DMEM_WS_STATS_EN
    // Count successful completions; the new count appears together with the valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rd_count <= '0;
            op_wr_count <= '0;
        end else if (go_resp && !cur_err) begin
            if (cur_op == RD) begin
                op_rd_count <= op_rd_count + 32'd1;
            end
            if (cur_op == WR) begin
                op_wr_count <= op_wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
